aes_uart_cmd_sequencer: RTL
===========================

Name: aes_uart_cmd_sequencer

Overview:
Command sequencer between the UART byte receiver and the AES core. It parses the received byte stream into commands, assembles the 128-bit key and plaintext, starts the AES core and waits for completion. It then returns an ACK/NAK status byte and the 16 ciphertext bytes to the UART transmitter over a valid/ready byte handshake.

Parameters:
TIMEOUT_CYCLES, 1000000, max clk cycles between consecutive payload bytes before the packet is aborted
ACK_BYTE, 8'h06, status byte returned on success
NAK_BYTE, 8'h15, status byte returned on reject/error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_byte  in  8  byte from UART receiver, valid when rx_done high
rx_done  in  1  one-cycle pulse per received byte
key  out  128  committed AES key
pt  out  128  committed plaintext
key_valid  out  1  a full key has been committed since reset
pt_valid  out  1  a full plaintext has been committed since reset
aes_start  out  1  one-cycle start pulse to AES core
aes_done  in  1  one-cycle pulse, ct valid in same cycle
ct  in  128  ciphertext from AES core
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
err_timeout  out  1  one-cycle pulse on inter-byte timeout abort
err_overrun  out  1  one-cycle pulse when rx_done arrives in a state not accepting bytes

Behaviour:
- Reset: all registers 0; state IDLE; key=pt=0; key_valid=pt_valid=0; aes_start=0; tx_valid=0; tx_data=0; err_*=0. Reset mid-operation aborts everything; no partial commit.
- States: IDLE, LOAD_KEY, LOAD_PT, START, WAIT_AES, SEND_STATUS, SEND_CT.
- IDLE, on rx_done:
  - 8'h4B ('K'): LOAD_KEY, byte count=0.
  - 8'h50 ('P'): LOAD_PT, count=0.
  - 8'h45 ('E'): START if key_valid && pt_valid, else SEND_STATUS with NAK.
  - Any other byte: SEND_STATUS with NAK.
- LOAD_KEY/LOAD_PT: each rx_done shifts rx_byte into a 128-bit shadow register from the LSB end. The first byte ends up in bits [127:120] (MSB-first).
  - On the 16th byte, in the same cycle: commit shadow to key/pt (including that byte), set key_valid/pt_valid, go to SEND_STATUS with ACK.
  - key/pt and the valid flags are unchanged until commit.
- Timeout: counter cleared on entry to LOAD_* and on every rx_done; increments each cycle in LOAD_*.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done in that cycle: pulse err_timeout, discard shadow, return to IDLE. No status byte is sent.
  - rx_done in the same cycle as expiry wins; the byte is accepted.
- START: aes_start=1 for exactly one cycle, then WAIT_AES.
- WAIT_AES: waits indefinitely for aes_done. On aes_done, capture ct into the tx shadow and enter SEND_STATUS with ACK, followed by SEND_CT.
- SEND_STATUS: tx_valid=1, tx_data=ACK/NAK. On handshake: go to SEND_CT if ct is pending, else IDLE.
- SEND_CT: sends 16 bytes MSB-first (ct[127:120] first), one per handshake. tx_valid may remain high back-to-back. After the 16th handshake, go to IDLE.
- tx_data/tx_valid must not change while tx_valid && !tx_ready.
- rx_done in START, WAIT_AES, SEND_STATUS or SEND_CT: byte dropped, err_overrun pulses the next cycle, state unaffected.
- Latency: 16th payload byte to tx_valid = 1 cycle; 'E' byte to aes_start = 1 cycle; aes_done to tx_valid = 1 cycle.
- Byte counter: 4 bits; terminal count 15 detected explicitly. No wrap into a 17th byte.

Decomposition:
- Package aes_uart_cmd_pkg: state enum; CMD_KEY=8'h4B, CMD_PT=8'h50, CMD_ENC=8'h45; ACK/NAK defaults; BLOCK_BYTES=16.
- One sub-module, byte_serializer128: 128-bit load, MSB-first byte output with valid/ready handshake and done pulse. Used for SEND_CT.

Test Plan:
- Send 'K' then bytes 00..0f -> key=128'h000102030405060708090a0b0c0d0e0f, key_valid=1, tx emits 8'h06.
- Send 'P' then 00 11 22 .. ff, then 'E'; model returns ct=128'h69c4e0d86a7b0430d8cdb78070b4c55a -> one aes_start pulse, tx emits 06, 69, c4, e0 .. 5a (17 bytes) with tx_ready stalled randomly, data held stable while stalled.
- 'E' after reset with no key -> no aes_start, tx emits 8'h15; unknown byte 8'h41 -> 8'h15.
- 'K' plus 5 bytes, then idle TIMEOUT_CYCLES (set to 100) -> err_timeout pulse, key and key_valid unchanged, no tx; next 'K' loads cleanly.
- rx_done during WAIT_AES -> err_overrun pulse; ct sequence still correct. Reset asserted mid LOAD_PT -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/aes_uart_cmd_sequencer_pkg.sv
// Shared definitions for the AES UART command sequencer.
// Contents: sequencer state encoding, command byte codes, default status
// bytes and block-size constants.
package aes_uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_KEY    = 3'd1,
        ST_LOAD_PT     = 3'd2,
        ST_START       = 3'd3,
        ST_WAIT_AES    = 3'd4,
        ST_SEND_STATUS = 3'd5,
        ST_SEND_CT     = 3'd6
    } state_e;

    localparam logic [7:0] CMD_KEY     = 8'h4B;  // 'K'
    localparam logic [7:0] CMD_PT      = 8'h50;  // 'P'
    localparam logic [7:0] CMD_ENC     = 8'h45;  // 'E'
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    localparam int         BLOCK_BYTES   = 16;
    localparam logic [3:0] LAST_BYTE_IDX = 4'(BLOCK_BYTES - 1);

endpackage

// File: rtl/aes_uart_cmd_sequencer_serializer.sv
// byte_serializer128: loads a 128-bit word and emits it MSB-first, one byte
// per valid/ready handshake.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load, load_data       load pulse and the word to send (load wins over
//                         any handshake in the same cycle)
//   out_valid, out_data   current byte (data_q[127:120]) while busy
//   out_ready             consumer accepts the byte when out_valid && out_ready
//   done                  combinational pulse on the 16th handshake
module byte_serializer128
    import aes_uart_cmd_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] load_data,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         done
);

    logic [127:0] data_q, data_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done   = 1'b0;
        if (load) begin
            data_d = load_data;
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q && out_ready) begin
            data_d = {data_q[119:0], 8'h00};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == LAST_BYTE_IDX) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign out_valid = busy_q;
    assign out_data  = data_q[127:120];

endmodule

// File: rtl/aes_uart_cmd_sequencer.sv
// aes_uart_cmd_sequencer: parses UART bytes into K/P/E commands, assembles
// the 128-bit key and plaintext, runs the AES core and returns a status byte
// (plus 16 ciphertext bytes after an encrypt) to the UART transmitter.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   rx_byte, rx_done        received byte and its one-cycle strobe
//   key, pt                 committed key / plaintext
//   key_valid, pt_valid     sticky "committed since reset" flags
//   aes_start               one-cycle start pulse to the AES core
//   aes_done, ct            AES completion pulse and ciphertext (same cycle)
//   tx_data, tx_valid,      byte stream to the transmitter
//   tx_ready
//   err_timeout             pulse after an inter-byte timeout abort
//   err_overrun             pulse the cycle after a byte arrived while busy
//   dbg_state               current sequencer state
//
// Handshake: a byte moves on every rising edge where tx_valid && tx_ready.
// While tx_valid && !tx_ready, tx_valid and tx_data hold their values.
module aes_uart_cmd_sequencer
    import aes_uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_byte,
    input  logic         rx_done,
    output logic [127:0] key,
    output logic [127:0] pt,
    output logic         key_valid,
    output logic         pt_valid,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] ct,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         err_timeout,
    output logic         err_overrun,
    output state_e       dbg_state
);

    localparam int            TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [127:0]   shadow_q, shadow_d;
    logic [127:0]   key_q, key_d, pt_q, pt_d;
    logic           key_valid_q, key_valid_d, pt_valid_q, pt_valid_d;
    logic [7:0]     status_q, status_d;
    logic           err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;

    logic           ser_load, ser_ready, ser_valid, ser_done;
    logic [7:0]     ser_data;

    // The serializer is loaded on aes_done, so it is already busy while the
    // status byte goes out; its busy flag doubles as "ciphertext pending".
    byte_serializer128 u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ct),
        .out_valid (ser_valid),
        .out_data  (ser_data),
        .out_ready (ser_ready),
        .done      (ser_done)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        shadow_d      = shadow_q;
        key_d         = key_q;
        pt_d          = pt_q;
        key_valid_d   = key_valid_q;
        pt_valid_d    = pt_valid_q;
        status_d      = status_q;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        ser_load      = 1'b0;
        ser_ready     = 1'b0;
        aes_start     = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    cnt_d    = 4'd0;
                    timer_d  = '0;
                    shadow_d = '0;
                    case (rx_byte)
                        CMD_KEY: state_d = ST_LOAD_KEY;
                        CMD_PT:  state_d = ST_LOAD_PT;
                        CMD_ENC: begin
                            if (key_valid_q && pt_valid_q) begin
                                state_d = ST_START;
                            end else begin
                                status_d = NAK_BYTE;
                                state_d  = ST_SEND_STATUS;
                            end
                        end
                        default: begin
                            status_d = NAK_BYTE;
                            state_d  = ST_SEND_STATUS;
                        end
                    endcase
                end
            end
            ST_LOAD_KEY, ST_LOAD_PT: begin
                // A byte arriving on the expiry cycle is still accepted.
                if (rx_done) begin
                    shadow_d = {shadow_q[119:0], rx_byte};
                    timer_d  = '0;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == LAST_BYTE_IDX) begin
                        if (state_q == ST_LOAD_KEY) begin
                            key_d       = shadow_d;
                            key_valid_d = 1'b1;
                        end else begin
                            pt_d       = shadow_d;
                            pt_valid_d = 1'b1;
                        end
                        status_d = ACK_BYTE;
                        state_d  = ST_SEND_STATUS;
                    end
                end else if (timer_q == TMAX) begin
                    err_timeout_d = 1'b1;
                    shadow_d      = '0;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_START: begin
                aes_start = 1'b1;
                state_d   = ST_WAIT_AES;
            end
            ST_WAIT_AES: begin
                if (aes_done) begin
                    ser_load = 1'b1;
                    status_d = ACK_BYTE;
                    state_d  = ST_SEND_STATUS;
                end
            end
            ST_SEND_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status_q;
                if (tx_ready) begin
                    state_d = ser_valid ? ST_SEND_CT : ST_IDLE;
                end
            end
            ST_SEND_CT: begin
                tx_valid  = ser_valid;
                tx_data   = ser_data;
                ser_ready = tx_ready;
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_done && (state_q == ST_START || state_q == ST_WAIT_AES ||
                        state_q == ST_SEND_STATUS || state_q == ST_SEND_CT)) begin
            err_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            timer_q       <= '0;
            shadow_q      <= '0;
            key_q         <= '0;
            pt_q          <= '0;
            key_valid_q   <= 1'b0;
            pt_valid_q    <= 1'b0;
            status_q      <= '0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            shadow_q      <= shadow_d;
            key_q         <= key_d;
            pt_q          <= pt_d;
            key_valid_q   <= key_valid_d;
            pt_valid_q    <= pt_valid_d;
            status_q      <= status_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign key         = key_q;
    assign pt          = pt_q;
    assign key_valid   = key_valid_q;
    assign pt_valid    = pt_valid_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign dbg_state   = state_q;

endmodule
